// File: rtl/pc_pkg.sv
// Shared defaults for the PC stage: alignment, reset/trap vectors
// and the select-width helper used by the source mux.
package pc_pkg;

  localparam int DEF_ALIGN_BITS = 2;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muxn.sv
// N-way next-PC source selector; any out-of-range
// select falls back to the last source.
module muxn
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  localparam int SEL_WIDTH = sel_width(NUM_SRC)
) (
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_i,
  input  logic [SEL_WIDTH-1:0]          sel_i,
  output logic [DATA_WIDTH-1:0]         out_o
);

  always_comb begin
    out_o = src_i[(NUM_SRC-1)*DATA_WIDTH +: DATA_WIDTH];
    for (int k = 0; k < NUM_SRC - 1; k++) begin
      if (sel_i == SEL_WIDTH'(k))
        out_o = src_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/pc_select_reg.sv
// PC register with source select, stall, queued late redirect
// and misaligned-target trap to a fixed vector.
module pc_select_reg
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int ALIGN_BITS = DEF_ALIGN_BITS,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR =
    DATA_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR =
    DATA_WIDTH'(DEF_TRAP_VECTOR),
  localparam int SEL_WIDTH = sel_width(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_i,
  input  logic [SEL_WIDTH-1:0]          sel,
  input  logic                          en,
  input  logic                          redirect_valid,
  input  logic [DATA_WIDTH-1:0]         redirect_target,
  output logic [DATA_WIDTH-1:0]         pc,
  output logic [DATA_WIDTH-1:0]         pc_plus4,
  output logic                          redirect_pending,
  output logic                          trap,
  output logic [DATA_WIDTH-1:0]         trap_addr
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] qtgt_q, qtgt_d;
  logic [DATA_WIDTH-1:0] taddr_q, taddr_d;
  logic                  pend_q, pend_d;
  logic                  trap_q, trap_d;
  logic [DATA_WIDTH-1:0] mux_out;
  logic [DATA_WIDTH-1:0] cand;
  logic                  misal;

  muxn #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SRC    (NUM_SRC)
  ) u_mux (
    .src_i (src_i),
    .sel_i (sel),
    .out_o (mux_out)
  );

  always_comb begin
    cand  = redirect_valid ? redirect_target :
            pend_q         ? qtgt_q : mux_out;
    misal = |cand[ALIGN_BITS-1:0];
  end

  always_comb begin
    pc_d    = pc_q;
    qtgt_d  = qtgt_q;
    taddr_d = taddr_q;
    pend_d  = pend_q;
    trap_d  = 1'b0;
    if (en) begin
      // queue always drains: consumed or superseded by live redirect
      pend_d  = 1'b0;
      pc_d    = misal ? TRAP_VECTOR : cand;
      trap_d  = misal;
      taddr_d = misal ? cand : taddr_q;
    end else if (redirect_valid) begin
      pend_d = 1'b1;
      qtgt_d = redirect_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      qtgt_q  <= '0;
      taddr_q <= '0;
      pend_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      qtgt_q  <= qtgt_d;
      taddr_q <= taddr_d;
      pend_q  <= pend_d;
      trap_q  <= trap_d;
    end
  end

  assign pc               = pc_q;
  assign pc_plus4         = pc_q + DATA_WIDTH'(4);
  assign redirect_pending = pend_q;
  assign trap             = trap_q;
  assign trap_addr        = taddr_q;

endmodule

// File: doc/pc_select_reg.md
# pc_select_reg

Parametrised program-counter source selector and PC register for the single-cycle core. Chooses the next PC from NUM_SRC candidate addresses, applies stalls, and queues a late redirect that arrives during a stall. Traps misaligned targets to a fixed vector. Sits in the PC stage, feeding instruction memory and the PC+4 adder path.

## Interface
Parameters:
- DATA_WIDTH, 32, address width
- NUM_SRC, 4, number of candidate next-PC sources (>= 2)
- SEL_WIDTH, $clog2(NUM_SRC), select width (derived, not overridden)
- ALIGN_BITS, 2, low address bits that must be zero
- RESET_VECTOR, 32'h0000_0000, PC after reset (must be aligned)
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned target (must be aligned)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- src_i  in  NUM_SRC*DATA_WIDTH  packed candidates, source k at [k*DATA_WIDTH +: DATA_WIDTH]
- sel  in  SEL_WIDTH  source index
- en  in  1  advance PC this cycle; 0 = stall
- redirect_valid  in  1  override request from a later stage
- redirect_target  in  DATA_WIDTH  override address
- pc  out  DATA_WIDTH  current PC (registered)
- pc_plus4  out  DATA_WIDTH  pc + 4, combinational, wraps modulo 2^DATA_WIDTH
- redirect_pending  out  1  a stalled redirect is queued (registered)
- trap  out  1  one-cycle pulse: last PC update hit a misaligned target
- trap_addr  out  DATA_WIDTH  faulting address of the most recent trap

## Operation
- Source mux: sel < NUM_SRC selects source sel; any sel >= NUM_SRC selects source NUM_SRC-1.
- Candidate next PC priority: live redirect (redirect_valid) > queued redirect > muxed source.
- Alignment: if candidate[ALIGN_BITS-1:0] != 0, PC loads TRAP_VECTOR, trap = 1 next cycle, trap_addr = candidate. Otherwise PC loads the candidate and trap = 0.
- en = 1: PC updates as above. The queued redirect is cleared whether it was consumed or superseded by a live redirect.
- en = 0: PC, trap_addr hold; trap = 0. If redirect_valid, target is written to the queue register and redirect_pending = 1. A newer redirect overwrites the queued one; latest wins.
- A queued misaligned target traps when consumed, not when captured.
- Reset (asynchronous, at any time including with a redirect queued): pc = RESET_VECTOR, redirect_pending = 0, queued target = 0, trap = 0, trap_addr = 0. Queued redirect is discarded.

## Timing
- Latency: src_i/sel/redirect to pc is 1 clock edge (with en = 1).
- Queued redirect applies on the first rising edge with en = 1 after capture. redirect_pending falls on that same edge.
- Same edge, en = 1, redirect_valid = 1 and redirect queued: live target loads, pending clears.
- trap asserts for exactly the cycle after the trapping edge. Back-to-back traps give trap high on consecutive cycles, with trap_addr updating each time.
- pc_plus4 follows pc combinationally; 32'hFFFF_FFFC + 4 = 32'h0.
- No combinational path from inputs to pc, redirect_pending, trap, trap_addr.

## Structure
- Package pc_pkg: ALIGN_BITS default, RESET_VECTOR/TRAP_VECTOR defaults, and a localparam helper for SEL_WIDTH.
- Sub-module muxn (parameters DATA_WIDTH, NUM_SRC): combinational N-way selector with the out-of-range rule above. All state lives in pc_select_reg.

## Test plan
- Reset: assert rst mid-cycle with redirect queued -> pc = 0x0, redirect_pending = 0, trap = 0 immediately, without waiting for a clock.
- Mux sweep, NUM_SRC = 3: src = {0x300, 0x200, 0x100}, sel = 0,1,2,3 with en = 1 -> pc = 0x100, 0x200, 0x300, 0x300.
- Stall and queue: en = 0, redirect 0x40 then 0x80 on consecutive cycles -> pc holds, redirect_pending = 1. Then en = 1 with sel -> 0x100 -> pc = 0x80, pending = 0.
- Live over queued: 0x40 queued, then en = 1 with redirect 0xC0 -> pc = 0xC0, pending = 0.
- Misalignment: en = 1, selected source = 0x102 -> pc = 0x100 (TRAP_VECTOR), trap pulses 1 cycle, trap_addr = 0x102. Repeat with a queued 0x206 -> trap_addr = 0x206.
- Wrap: pc = 0xFFFF_FFFC -> pc_plus4 = 0x0. Selecting pc_plus4 as a source with en = 1 -> pc = 0x0, no trap.
